// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the byte-serialising RAM word arbiter.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        DRAIN,
        ACK
    } state_t;

    localparam int NREQ           = 2;
    localparam int BYTES_PER_WORD = 4;
    localparam int PORT_FETCH     = 0;
    localparam int PORT_DATA      = 1;

    function automatic logic [NREQ-1:0] port_onehot(input logic port);
        return (port == 1'(PORT_DATA)) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: combinational winner, pointer advanced by the caller.
module rr_pick2
    import ram_arb_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic            update,
    output logic            winner
);

    logic last;

    always_comb begin
        winner = ~last;
        if (req == 2'b01) begin
            winner = 1'(PORT_FETCH);
        end else if (req == 2'b10) begin
            winner = 1'(PORT_DATA);
        end
    end

    // last = 1 after reset so the fetch port wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            last <= 1'b1;
        end else if (update) begin
            last <= winner;
        end
    end

endmodule

// File: rtl/ram_word_arbiter.sv
// Arbitrates two 32-bit word ports onto a byte-wide RAM, four little-endian bytes per word.
// Define RAM_ARB_BOUNDS_CHECK_EN to reject words that would run past RAMSIZE (err pulses with ack).
module ram_word_arbiter
    import ram_arb_pkg::*;
#(
    parameter int RAMSIZE = 64,
    parameter int ADDRW   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [1:0]       we,
    input  logic [ADDRW-1:0] addr0,
    input  logic [ADDRW-1:0] addr1,
    input  logic [31:0]      wdata0,
    input  logic [31:0]      wdata1,
    output logic [1:0]       gnt,
    output logic [1:0]       ack,
    output logic [31:0]      rdata,
    output logic             err,
    output logic             ram_en,
    output logic             ram_we,
    output logic [ADDRW-1:0] ram_addr,
    output logic [7:0]       ram_wdata,
    input  logic [7:0]       ram_rdata
);

    localparam logic [1:0] LAST_K = 2'(BYTES_PER_WORD - 1);

    state_t            state;
    logic [1:0]        k;
    logic              winner;
    logic              win_q;
    logic              we_q;
    logic              oob_q;
    logic [31:0]       wd_q;
    logic [23:0]       rbuf;
    logic              start;
    logic [ADDRW-1:0]  base_sel;
    logic              we_sel;
    logic [31:0]       wd_sel;
    logic              oob;

    assign start    = (state == IDLE) && (|req);
    assign base_sel = winner ? addr1 : addr0;
    assign we_sel   = winner ? we[1] : we[0];
    assign wd_sel   = winner ? wdata1 : wdata0;

`ifdef RAM_ARB_BOUNDS_CHECK_EN
    assign oob = ({1'b0, base_sel} + (ADDRW+1)'(BYTES_PER_WORD - 1)) >= (ADDRW+1)'(RAMSIZE);
`else
    assign oob = 1'b0;
`endif

    rr_pick2 u_pick (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .update (start),
        .winner (winner)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            k         <= '0;
            win_q     <= 1'b0;
            we_q      <= 1'b0;
            oob_q     <= 1'b0;
            wd_q      <= '0;
            rbuf      <= '0;
            gnt       <= '0;
            ack       <= '0;
            rdata     <= '0;
            err       <= 1'b0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            gnt   <= '0;
            ack   <= '0;
            err   <= 1'b0;
            rdata <= '0;
            case (state)
                IDLE: begin
                    if (start) begin
                        win_q <= winner;
                        we_q  <= we_sel;
                        oob_q <= oob;
                        gnt   <= port_onehot(winner);
                        k     <= '0;
                        if (oob) begin
                            state <= DRAIN;
                        end else begin
                            state     <= XFER;
                            ram_en    <= 1'b1;
                            ram_we    <= we_sel;
                            ram_addr  <= base_sel;
                            ram_wdata <= wd_sel[7:0];
                            wd_q      <= wd_sel >> 8;
                        end
                    end
                end
                XFER: begin
                    // Read bytes arrive one cycle late; shift them in low byte first.
                    if (k != 2'd0) begin
                        rbuf <= {ram_rdata, rbuf[23:8]};
                    end
                    if (k == LAST_K) begin
                        state     <= DRAIN;
                        ram_en    <= 1'b0;
                        ram_we    <= 1'b0;
                        ram_addr  <= '0;
                        ram_wdata <= '0;
                    end else begin
                        k         <= k + 2'd1;
                        ram_addr  <= ram_addr + 1'b1;
                        ram_wdata <= wd_q[7:0];
                        wd_q      <= wd_q >> 8;
                    end
                end
                DRAIN: begin
                    state <= ACK;
                    ack   <= port_onehot(win_q);
                    err   <= oob_q;
                    rdata <= (we_q || oob_q) ? '0 : {ram_rdata, rbuf};
                end
                ACK: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_word_arbiter.sv
// Directed bench for ram_word_arbiter with a behavioural byte RAM; honours RAM_ARB_BOUNDS_CHECK_EN.
module tb_ram_word_arbiter;

    logic        clk;
    logic        reset;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [7:0]  addr0;
    logic [7:0]  addr1;
    logic [31:0] wdata0;
    logic [31:0] wdata1;
    logic [1:0]  gnt;
    logic [1:0]  ack;
    logic [31:0] rdata;
    logic        err;
    logic        ram_en;
    logic        ram_we;
    logic [7:0]  ram_addr;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;

    logic [7:0]  mem [256];

    int tests;
    int fails;

    // observations from the last run_word call
    logic [1:0]  obs_gnt;
    int          obs_gnt_cnt;
    logic [7:0]  obs_addr [4];
    logic [7:0]  obs_wd [4];
    logic [3:0]  obs_we;
    logic [5:0]  obs_en;
    int          obs_ack_cyc;
    logic [1:0]  obs_ack;
    logic [31:0] obs_rdata;
    logic        obs_err;

    ram_word_arbiter #(.RAMSIZE(64), .ADDRW(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .we        (we),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .gnt       (gnt),
        .ack       (ack),
        .rdata     (rdata),
        .err       (err),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Caller is in an IDLE cycle; this cycle becomes t0. Returns in the following IDLE cycle.
    task automatic run_word(input int port, input logic w, input logic [7:0] a, input logic [31:0] d);
        obs_gnt = '0; obs_gnt_cnt = 0; obs_we = '0; obs_en = '0;
        obs_ack_cyc = 0; obs_ack = '0; obs_rdata = '0; obs_err = 1'b0;
        for (int i = 0; i < 4; i++) begin
            obs_addr[i] = '0;
            obs_wd[i]   = '0;
        end
        if (port == 0) begin
            addr0 = a; wdata0 = d; we[0] = w; req[0] = 1'b1;
        end else begin
            addr1 = a; wdata1 = d; we[1] = w; req[1] = 1'b1;
        end
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (c == 1) obs_gnt = gnt;
            if (gnt != 2'b00) obs_gnt_cnt++;
            if (c <= 6) obs_en[c-1] = ram_en;
            if (c <= 4) begin
                obs_addr[c-1] = ram_addr;
                obs_wd[c-1]   = ram_wdata;
                obs_we[c-1]   = ram_we;
            end
            if (ack != 2'b00) begin
                obs_ack_cyc = c;
                obs_ack     = ack;
                obs_rdata   = rdata;
                obs_err     = err;
                break;
            end
        end
        req = 2'b00;
        tick();
    endtask

    task automatic test_reset;
        reset = 1'b1;
        req   = 2'b11;
        tick();
        tick();
        tests++;
        if ({gnt, ack, rdata, err, ram_en, ram_we, ram_addr, ram_wdata} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: gnt=%b ack=%b rdata=%h err=%b en=%b we=%b addr=%h wd=%h, required all 0",
                     gnt, ack, rdata, err, ram_en, ram_we, ram_addr, ram_wdata);
        end
        req   = 2'b00;
        reset = 1'b0;
        tick();
        tests++;
        if (gnt !== 2'b00) begin
            fails++;
            $display("FAIL reset_idle_gnt: got %b, required 00", gnt);
        end
    endtask

    task automatic test_read;
        run_word(0, 1'b0, 8'd16, 32'h0);
        tests++;
        if (obs_gnt !== 2'b01) begin
            fails++; $display("FAIL read_gnt: got %b, required 01", obs_gnt);
        end
        tests++;
        if ({obs_addr[0], obs_addr[1], obs_addr[2], obs_addr[3]} !== {8'd16, 8'd17, 8'd18, 8'd19}) begin
            fails++; $display("FAIL read_addr: got %0d %0d %0d %0d, required 16 17 18 19",
                              obs_addr[0], obs_addr[1], obs_addr[2], obs_addr[3]);
        end
        tests++;
        if (obs_en !== 6'b001111 || obs_we !== 4'b0000) begin
            fails++; $display("FAIL read_en: en=%b we=%b, required en=001111 we=0000", obs_en, obs_we);
        end
        tests++;
        if (obs_ack_cyc != 6 || obs_ack !== 2'b01) begin
            fails++; $display("FAIL read_ack: cycle %0d ack %b, required cycle 6 ack 01", obs_ack_cyc, obs_ack);
        end
        tests++;
        if (obs_rdata !== 32'h447a0000 || obs_err !== 1'b0) begin
            fails++; $display("FAIL read_data: rdata=%h err=%b, required 447a0000 err 0", obs_rdata, obs_err);
        end
    endtask

    task automatic test_write_read;
        run_word(1, 1'b1, 8'd20, 32'hc1200000);
        tests++;
        if (obs_ack_cyc != 6 || obs_ack !== 2'b10 || obs_rdata !== 32'h0) begin
            fails++; $display("FAIL write_ack: cycle %0d ack %b rdata %h, required 6 10 00000000",
                              obs_ack_cyc, obs_ack, obs_rdata);
        end
        tests++;
        if ({mem[23], mem[22], mem[21], mem[20]} !== 32'hc1200000) begin
            fails++; $display("FAIL write_mem: RAM[23..20]=%h%h%h%h, required c1200000",
                              mem[23], mem[22], mem[21], mem[20]);
        end
        run_word(1, 1'b0, 8'd20, 32'h0);
        tests++;
        if (obs_ack !== 2'b10 || obs_rdata !== 32'hc1200000) begin
            fails++; $display("FAIL readback: ack %b rdata %h, required 10 c1200000", obs_ack, obs_rdata);
        end
    endtask

    task automatic test_write_order;
        run_word(1, 1'b1, 8'h30, 32'ha1b2c3d4);
        tests++;
        if ({obs_wd[0], obs_wd[1], obs_wd[2], obs_wd[3]} !== 32'hd4c3b2a1) begin
            fails++; $display("FAIL wr_order: got %h %h %h %h, required d4 c3 b2 a1",
                              obs_wd[0], obs_wd[1], obs_wd[2], obs_wd[3]);
        end
        tests++;
        if (obs_we !== 4'b1111 || obs_gnt_cnt != 1 || obs_gnt !== 2'b10) begin
            fails++; $display("FAIL wr_strobe: we=%b gnts=%0d gnt=%b, required 1111 1 10",
                              obs_we, obs_gnt_cnt, obs_gnt);
        end
    endtask

    task automatic test_bounds;
        run_word(0, 1'b0, 8'd62, 32'h0);
`ifdef RAM_ARB_BOUNDS_CHECK_EN
        tests++;
        if (obs_ack_cyc != 2 || obs_ack !== 2'b01 || obs_err !== 1'b1) begin
            fails++; $display("FAIL bounds_ack: cycle %0d ack %b err %b, required 2 01 1",
                              obs_ack_cyc, obs_ack, obs_err);
        end
        tests++;
        if (obs_rdata !== 32'h0 || obs_en !== 6'b000000 || obs_gnt !== 2'b01) begin
            fails++; $display("FAIL bounds_quiet: rdata %h en %b gnt %b, required 0 000000 01",
                              obs_rdata, obs_en, obs_gnt);
        end
`else
        tests++;
        if ({obs_addr[0], obs_addr[1], obs_addr[2], obs_addr[3]} !== {8'd62, 8'd63, 8'd64, 8'd65}) begin
            fails++; $display("FAIL bounds_addr: got %0d %0d %0d %0d, required 62 63 64 65",
                              obs_addr[0], obs_addr[1], obs_addr[2], obs_addr[3]);
        end
        tests++;
        if (obs_ack_cyc != 6 || obs_err !== 1'b0 || obs_rdata !== 32'h44332211) begin
            fails++; $display("FAIL bounds_data: cycle %0d err %b rdata %h, required 6 0 44332211",
                              obs_ack_cyc, obs_err, obs_rdata);
        end
`endif
    endtask

    task automatic test_round_robin;
        logic [1:0]  g [4];
        logic [1:0]  ap [4];
        logic [31:0] ad [4];
        int          ac [4];
        int          ng;
        int          na;
        ng = 0; na = 0;
        for (int i = 0; i < 4; i++) begin
            g[i] = '0; ap[i] = '0; ad[i] = '0; ac[i] = 0;
        end
        reset = 1'b1;
        we    = 2'b00;
        addr0 = 8'd16;
        addr1 = 8'd20;
        req   = 2'b11;
        tick();
        reset = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (gnt != 2'b00 && ng < 4) begin g[ng] = gnt; ng++; end
            if (ack != 2'b00 && na < 4) begin
                ac[na] = c; ap[na] = ack; ad[na] = rdata; na++;
            end
            if (na == 4) break;
        end
        req = 2'b00;
        tick();
        tests++;
        if ({g[0], g[1], g[2], g[3]} !== 8'b01_10_01_10) begin
            fails++; $display("FAIL rr_order: got %b %b %b %b, required 01 10 01 10", g[0], g[1], g[2], g[3]);
        end
        tests++;
        if (ac[0] != 6 || ac[1] != 13 || ac[2] != 20 || ac[3] != 27) begin
            fails++; $display("FAIL rr_spacing: ack cycles %0d %0d %0d %0d, required 6 13 20 27",
                              ac[0], ac[1], ac[2], ac[3]);
        end
        tests++;
        if ({ap[0], ap[1], ap[2], ap[3]} !== 8'b01_10_01_10 ||
            ad[0] !== 32'h447a0000 || ad[1] !== 32'hc1200000) begin
            fails++; $display("FAIL rr_acks: ack %b %b %b %b data %h %h, required 01 10 01 10 447a0000 c1200000",
                              ap[0], ap[1], ap[2], ap[3], ad[0], ad[1]);
        end
    endtask

    task automatic test_reset_mid;
        addr0  = 8'd8;
        wdata0 = 32'h11223344;
        we[0]  = 1'b1;
        req    = 2'b01;
        tick();
        tick();
        // reset sampled at the end of t0+2: bytes for addr 8 and 9 are written, 10 is not
        reset = 1'b1;
        req   = 2'b00;
        tick();
        tests++;
        if ({gnt, ack, rdata, err, ram_en, ram_we, ram_addr, ram_wdata} !== '0) begin
            fails++;
            $display("FAIL midreset_outputs: gnt=%b ack=%b rdata=%h en=%b we=%b addr=%h wd=%h, required all 0",
                     gnt, ack, rdata, ram_en, ram_we, ram_addr, ram_wdata);
        end
        reset = 1'b0;
        tick();
        tests++;
        if ({mem[11], mem[10], mem[9], mem[8]} !== 32'hddcc3344) begin
            fails++; $display("FAIL midreset_mem: RAM[11..8]=%h%h%h%h, required ddcc3344",
                              mem[11], mem[10], mem[9], mem[8]);
        end
        run_word(0, 1'b0, 8'd8, 32'h0);
        tests++;
        if (obs_ack_cyc != 6 || obs_ack !== 2'b01 || obs_rdata !== 32'hddcc3344) begin
            fails++; $display("FAIL midreset_read: cycle %0d ack %b rdata %h, required 6 01 ddcc3344",
                              obs_ack_cyc, obs_ack, obs_rdata);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[16] = 8'h00; mem[17] = 8'h00; mem[18] = 8'h7a; mem[19] = 8'h44;
        mem[8]  = 8'haa; mem[9]  = 8'hbb; mem[10] = 8'hcc; mem[11] = 8'hdd;
        mem[62] = 8'h11; mem[63] = 8'h22; mem[64] = 8'h33; mem[65] = 8'h44;
        ram_rdata = 8'h00;
        reset  = 1'b1;
        req    = 2'b00;
        we     = 2'b00;
        addr0  = '0;
        addr1  = '0;
        wdata0 = '0;
        wdata1 = '0;

        test_reset();
        test_read();
        test_write_read();
        test_write_order();
        test_bounds();
        test_round_robin();
        test_reset_mid();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
